// File: rtl/stream_demux_if.sv
// stream_demux_if: source and sink handshake bundle for stream_demux.
// The slave modport is the demux view; the master modport drives it.
interface stream_demux_if #(
    parameter int DataWidth = 32,
    parameter int Outputs   = 4,
    parameter int SelWidth  = 2
);
    logic                           in_valid;
    logic                           in_ready;
    logic [DataWidth-1:0]           in_data;
    logic [SelWidth-1:0]            in_sel;
    logic [Outputs-1:0]             out_valid;
    logic [Outputs-1:0]             out_ready;
    logic [Outputs*DataWidth-1:0]   out_data;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N valid/ready demux, one holding slot per sink.
// Define STREAM_DEMUX_ERR_EN to add the sticky err/err_sel bad-select capture.
module stream_demux #(
    parameter int DataWidth = 32,
    parameter int Outputs   = 4,
    parameter int SelWidth  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_demux_if.slave       bus
`ifdef STREAM_DEMUX_ERR_EN
    ,
    output logic                err,
    output logic [SelWidth-1:0] err_sel
`endif
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e                state_q [Outputs];
    slot_e                state_d [Outputs];
    logic [DataWidth-1:0] data_q  [Outputs];
    logic [DataWidth-1:0] data_d  [Outputs];
    logic [Outputs-1:0]   hit;
    logic                 stall;
    logic                 accept;

    // Out-of-range selects hit no slot, so they never stall.
    always_comb begin
        hit   = '0;
        stall = 1'b0;
        for (int unsigned k = 0; k < Outputs; k++) begin
            if (32'(bus.in_sel) == k) begin
                hit[k] = 1'b1;
                stall  = (state_q[k] == FULL) && !bus.out_ready[k];
            end
        end
    end

    assign bus.in_ready = rst_n && !stall;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        for (int unsigned k = 0; k < Outputs; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            unique case (state_q[k])
                EMPTY: begin
                    if (accept && hit[k]) begin
                        state_d[k] = FULL;
                        data_d[k]  = bus.in_data;
                    end
                end
                FULL: begin
                    if (accept && hit[k]) begin
                        data_d[k] = bus.in_data;
                    end else if (bus.out_ready[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int unsigned k = 0; k < Outputs; k++) begin
            bus.out_valid[k] = (state_q[k] == FULL);
            bus.out_data[k*DataWidth +: DataWidth] = data_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < Outputs; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < Outputs; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

`ifdef STREAM_DEMUX_ERR_EN
    logic                err_q;
    logic                err_d;
    logic [SelWidth-1:0] err_sel_q;
    logic [SelWidth-1:0] err_sel_d;

    // Only the first offending select is kept until reset.
    always_comb begin
        err_d     = err_q;
        err_sel_d = err_sel_q;
        if (accept && !(|hit) && !err_q) begin
            err_d     = 1'b1;
            err_sel_d = bus.in_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_sel_q <= '0;
        end else begin
            err_q     <= err_d;
            err_sel_q <= err_sel_d;
        end
    end

    assign err     = err_q;
    assign err_sel = err_sel_q;
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: vector table, hand sequences and a queue-model random run.
// dut_a is the 4-sink build, dut_b a 3-sink build exercising bad selects.
`timescale 1ns/1ps
module tb_stream_demux;
    localparam int DW = 32;
    localparam int NA = 4;
    localparam int SA = 2;
    localparam int NB = 3;
    localparam int SB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    stream_demux_if #(.DataWidth(DW), .Outputs(NA), .SelWidth(SA)) ifa ();
    stream_demux_if #(.DataWidth(DW), .Outputs(NB), .SelWidth(SB)) ifb ();

`ifdef STREAM_DEMUX_ERR_EN
    logic          err_a;
    logic [SA-1:0] err_sel_a;
    logic          err_b;
    logic [SB-1:0] err_sel_b;
`endif

    stream_demux #(.DataWidth(DW), .Outputs(NA), .SelWidth(SA)) dut_a (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifa)
`ifdef STREAM_DEMUX_ERR_EN
        ,
        .err(err_a),
        .err_sel(err_sel_a)
`endif
    );

    stream_demux #(.DataWidth(DW), .Outputs(NB), .SelWidth(SB)) dut_b (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifb)
`ifdef STREAM_DEMUX_ERR_EN
        ,
        .err(err_b),
        .err_sel(err_sel_b)
`endif
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        int          ck;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] mq[NA][$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [1:0] sel,
                                input logic [31:0] d, input logic [3:0] rdy,
                                input logic er, input logic [3:0] eov,
                                input int ck, input logic [31:0] ed);
        vec_t r;
        r.v = v; r.sel = sel; r.d = d; r.rdy = rdy;
        r.exp_rdy = er; r.exp_ov = eov; r.ck = ck; r.exp_d = ed;
        tbl.push_back(r);
    endfunction

    task automatic idle();
        ifa.in_valid = 1'b0; ifa.in_sel = '0;
        ifa.in_data = '0; ifa.out_ready = '0;
        ifb.in_valid = 1'b0; ifb.in_sel = '0;
        ifb.in_data = '0; ifb.out_ready = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_r;
        logic acc;
        logic hold;

        idle();
        rst_n = 1'b0;
        ifa.in_valid = 1'b1;
        #12;
        chk("reset out_valid", 64'(ifa.out_valid), 64'h0);
        chk("reset out_data", 64'(ifa.out_data[63:0]), 64'h0);
        chk("reset in_ready", 64'(ifa.in_ready), 64'h0);
        ifa.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // single transfer and drain
        add(1, 2, 32'hA5A5_0001, 4'hF, 1, 4'b0100, 2, 32'hA5A5_0001);
        add(0, 0, 0, 4'hF, 1, 4'b0000, -1, 0);
        // stall then back-to-back replace
        add(1, 1, 32'h11, 4'b1101, 1, 4'b0010, 1, 32'h11);
        add(1, 1, 32'h22, 4'b1101, 0, 4'b0010, 1, 32'h11);
        add(1, 1, 32'h22, 4'b1111, 1, 4'b0010, 1, 32'h22);
        add(0, 0, 0, 4'hF, 1, 4'b0000, -1, 0);
        // streaming without bubbles
        for (int i = 1; i <= 8; i++)
            add(1, 3, 32'(i), 4'hF, 1, 4'b1000, 3, 32'(i));
        add(0, 0, 0, 4'hF, 1, 4'b0000, -1, 0);
        // stalled sink does not block another sink
        add(1, 0, 32'hAAAA, 4'b1110, 1, 4'b0001, 0, 32'hAAAA);
        add(1, 0, 32'hBBBB, 4'b1110, 0, 4'b0001, 0, 32'hAAAA);
        add(1, 1, 32'hBEEF, 4'b1100, 1, 4'b0011, 1, 32'hBEEF);
        add(0, 0, 0, 4'b1100, 0, 4'b0011, 0, 32'hAAAA);
        add(0, 2, 0, 4'hF, 1, 4'b0000, -1, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            ifa.in_valid = tbl[i].v;
            ifa.in_sel = tbl[i].sel;
            ifa.in_data = tbl[i].d;
            ifa.out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d in_ready", i), 64'(ifa.in_ready),
                64'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d out_valid", i), 64'(ifa.out_valid),
                64'(tbl[i].exp_ov));
            if (tbl[i].ck >= 0)
                chk($sformatf("row%0d out_data", i),
                    64'(ifa.out_data[tbl[i].ck*DW +: DW]), 64'(tbl[i].exp_d));
        end

        // async reset discards held entries
        @(negedge clk);
        ifa.in_valid = 1'b1; ifa.in_sel = 2'd0;
        ifa.in_data = 32'hC0; ifa.out_ready = 4'h0;
        @(negedge clk);
        ifa.in_sel = 2'd2; ifa.in_data = 32'hC2;
        @(negedge clk);
        ifa.in_sel = 2'd0;
        #1;
        chk("fill out_valid", 64'(ifa.out_valid), 64'b0101);
        chk("fill slice0", 64'(ifa.out_data[0 +: DW]), 64'hC0);
        chk("fill slice2", 64'(ifa.out_data[2*DW +: DW]), 64'hC2);
        chk("fill stall", 64'(ifa.in_ready), 64'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 64'(ifa.out_valid), 64'h0);
        chk("async out_data", 64'(ifa.out_data[63:0]), 64'h0);
        ifa.in_sel = 2'd1;
        #1;
        chk("async in_ready", 64'(ifa.in_ready), 64'h0);
        ifa.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ifa.in_sel = 2'd0;
        #1;
        chk("post-reset in_ready", 64'(ifa.in_ready), 64'h1);
        chk("post-reset out_valid", 64'(ifa.out_valid), 64'h0);

        // out-of-range selects on the 3-sink build
        do_reset();
`ifdef STREAM_DEMUX_ERR_EN
        #1;
        chk("err idle", 64'(err_b), 64'h0);
`endif
        @(negedge clk);
        ifb.in_valid = 1'b1; ifb.in_sel = 3'd3;
        ifb.in_data = 32'hDEAD; ifb.out_ready = 3'b000;
        #1;
        chk("bad1 in_ready", 64'(ifb.in_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("bad1 out_valid", 64'(ifb.out_valid), 64'h0);
`ifdef STREAM_DEMUX_ERR_EN
        chk("bad1 err", 64'(err_b), 64'h1);
        chk("bad1 err_sel", 64'(err_sel_b), 64'h3);
`endif
        @(negedge clk);
        ifb.in_sel = 3'd5; ifb.in_data = 32'h77; ifb.out_ready = 3'b111;
        #1;
        chk("bad2 in_ready", 64'(ifb.in_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("bad2 out_valid", 64'(ifb.out_valid), 64'h0);
`ifdef STREAM_DEMUX_ERR_EN
        chk("bad2 err_sel", 64'(err_sel_b), 64'h3);
`endif
        @(negedge clk);
        ifb.in_sel = 3'd0; ifb.in_data = 32'h55;
        #1;
        chk("good in_ready", 64'(ifb.in_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("good out_valid", 64'(ifb.out_valid), 64'b001);
        chk("good out_data", 64'(ifb.out_data[0 +: DW]), 64'h55);
        @(negedge clk);
        ifb.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("good drained", 64'(ifb.out_valid), 64'h0);

        // random traffic against a queue-per-sink model (capacity one)
        do_reset();
        foreach (mq[k]) mq[k].delete();
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < NA; k++) begin
                chk($sformatf("rnd%0d valid%0d", c, k),
                    64'(ifa.out_valid[k]), 64'(mq[k].size() != 0));
                if (mq[k].size() != 0)
                    chk($sformatf("rnd%0d data%0d", c, k),
                        64'(ifa.out_data[k*DW +: DW]), 64'(mq[k][0]));
            end
            if (!hold) begin
                ifa.in_valid = ($urandom_range(0, 3) != 0);
                ifa.in_sel = 2'($urandom_range(0, NA - 1));
                ifa.in_data = $urandom;
            end
            ifa.out_ready = 4'($urandom_range(0, 15));
            #1;
            exp_r = (mq[ifa.in_sel].size() == 0) || ifa.out_ready[ifa.in_sel];
            chk($sformatf("rnd%0d in_ready", c), 64'(ifa.in_ready), 64'(exp_r));
            acc = ifa.in_valid && exp_r;
            hold = ifa.in_valid && !exp_r;
            @(posedge clk);
            for (int k = 0; k < NA; k++)
                if (ifa.out_ready[k] && mq[k].size() != 0)
                    void'(mq[k].pop_front());
            if (acc) mq[ifa.in_sel].push_back(ifa.in_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
